// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame controller: start detect, bit timing, deserialize, parity/stop check
module uart_rx_ctrl #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      sampled_bit,
  output logic                      dat_samp_en,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] MIN_P = PRESCALE_WIDTH'(8);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [PRESCALE_WIDTH-1:0] p_q, p_d;
  logic [BCW-1:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]     pdata_q, pdata_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      perr_flag_q, perr_flag_d;
  logic                      dv_q, dv_d;
  logic                      perr_q, perr_d;
  logic                      serr_q, serr_d;
  logic                      bit_end;

  // Last edge of the current bit period; only meaningful while a frame is in progress.
  assign bit_end = (state_q != S_IDLE) && (edge_q == p_q - PRESCALE_WIDTH'(1));

  // State, counters, datapath and output pulse registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      edge_q      <= '0;
      p_q         <= MIN_P;
      bit_q       <= '0;
      shreg_q     <= '0;
      pdata_q     <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      perr_flag_q <= 1'b0;
      dv_q        <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      p_q         <= p_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      pdata_q     <= pdata_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      perr_flag_q <= perr_flag_d;
      dv_q        <= dv_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
    end
  end

  // Next-state, bit timing, deserialization and frame checks.
  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    p_d         = p_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    pdata_d     = pdata_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    perr_flag_d = perr_flag_q;
    dv_d        = 1'b0;
    perr_d      = 1'b0;
    serr_d      = 1'b0;
    dat_samp_en = 1'b0;

    if (state_q == S_IDLE) begin
      edge_d = '0;
      if (!RX_IN) begin
        // Detect cycle is edge 0 of the start bit; freeze frame config here.
        state_d     = S_START;
        edge_d      = PRESCALE_WIDTH'(1);
        p_d         = (Prescale < MIN_P) ? MIN_P : Prescale;
        par_en_d    = PAR_EN;
        par_typ_d   = PAR_TYP;
        perr_flag_d = 1'b0;
      end
    end else begin
      dat_samp_en = 1'b1;
      edge_d      = bit_end ? '0 : edge_q + PRESCALE_WIDTH'(1);
      if (bit_end) begin
        case (state_q)
          S_START: begin
            if (!sampled_bit) begin
              state_d = S_DATA;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
          S_DATA: begin
            shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
            bit_d   = bit_q + BCW'(1);
            if (bit_q == BCW'(DATA_WIDTH - 1)) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            perr_flag_d = par_en_q & (sampled_bit ^ (^shreg_q) ^ par_typ_q);
            state_d     = S_STOP;
          end
          S_STOP: begin
            state_d = S_IDLE;
            serr_d  = ~sampled_bit;
            perr_d  = perr_flag_q;
            dv_d    = sampled_bit & ~perr_flag_q;
            if (dv_d) begin
              pdata_d = shreg_q;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign edge_cnt   = edge_q;
  assign P_DATA     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = perr_q;
  assign stp_err    = serr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       sampled_bit;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c1, c2;

  // Ideal sampler: the line is clean, so the voted bit equals the line.
  assign sampled_bit = RX_IN;

  uart_rx_ctrl #(.PRESCALE_WIDTH(6), .DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .sampled_bit(sampled_bit), .dat_samp_en(dat_samp_en),
    .edge_cnt(edge_cnt), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                            input logic sbit, input int p);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (has_par) drive_bit(pbit, p);
    drive_bit(sbit, p);
  endtask

  initial begin
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    tick(); tick();
    check("rst_dv", data_valid, 0);
    check("rst_pdata", P_DATA, 8'h00);
    check("rst_edge", edge_cnt, 0);
    check("rst_samp_en", dat_samp_en, 0);
    check("rst_perr", par_err, 0);
    check("rst_serr", stp_err, 0);
    RST = 1'b1;
    tick(); tick();

    // 1: even parity, 0xA5, parity bit 0
    PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd8;
    send_frame(8'hA5, 1, 1'b0, 1'b1, 8);
    check("t1_dv", data_valid, 1);
    check("t1_pdata", P_DATA, 8'hA5);
    check("t1_perr", par_err, 0);
    check("t1_serr", stp_err, 0);
    check("t1_idle_samp_en", dat_samp_en, 0);
    tick();
    check("t1_dv_one_cycle", data_valid, 0);

    // 2: wrong parity, then bad stop bit
    send_frame(8'hA5, 1, 1'b1, 1'b1, 8);
    check("t2_perr", par_err, 1);
    check("t2_dv", data_valid, 0);
    check("t2_pdata_hold", P_DATA, 8'hA5);
    tick();
    check("t2_perr_one_cycle", par_err, 0);
    send_frame(8'h11, 1, 1'b0, 1'b0, 8);
    RX_IN = 1'b1;
    check("t2_serr", stp_err, 1);
    check("t2b_perr", par_err, 0);
    check("t2b_dv", data_valid, 0);
    check("t2b_pdata_hold", P_DATA, 8'hA5);
    tick();
    check("t2_serr_one_cycle", stp_err, 0);
    tick(); tick();

    // 3: start glitch, line low 3 cycles
    RX_IN = 1'b0;
    tick();
    check("t3_edge1", edge_cnt, 1);
    check("t3_samp_en", dat_samp_en, 1);
    tick(); tick();
    RX_IN = 1'b1;
    repeat (4) tick();
    check("t3_edge7", edge_cnt, 7);
    check("t3_samp_en_hold", dat_samp_en, 1);
    tick();
    check("t3_abort_samp_en", dat_samp_en, 0);
    check("t3_abort_edge", edge_cnt, 0);
    check("t3_dv", data_valid, 0);
    check("t3_perr", par_err, 0);
    check("t3_serr", stp_err, 0);
    repeat (10) tick();
    check("t3_no_late_pulse", {data_valid, par_err, stp_err}, 3'b000);

    // 4: P=32, no parity, back-to-back frames
    PAR_EN = 1'b0; Prescale = 6'd32;
    send_frame(8'h00, 0, 1'b0, 1'b1, 32);
    c1 = cyc;
    check("t4_dv0", data_valid, 1);
    check("t4_pdata0", P_DATA, 8'h00);
    send_frame(8'hFF, 0, 1'b0, 1'b1, 32);
    c2 = cyc;
    check("t4_dv1", data_valid, 1);
    check("t4_pdata1", P_DATA, 8'hFF);
    check("t4_spacing", c2 - c1, 320);
    tick(); tick();

    // 5: odd parity, 0x01
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    send_frame(8'h01, 1, 1'b0, 1'b1, 16);
    check("t5_dv", data_valid, 1);
    check("t5_pdata", P_DATA, 8'h01);
    check("t5_perr", par_err, 0);
    tick();
    send_frame(8'h01, 1, 1'b1, 1'b1, 16);
    check("t5_perr_bad", par_err, 1);
    check("t5_dv_bad", data_valid, 0);
    check("t5_pdata_hold", P_DATA, 8'h01);
    tick(); tick();

    // 6: reset mid-frame, then clean frame with Prescale below minimum
    Prescale = 6'd8; PAR_EN = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
    repeat (3) tick();
    check("t6_in_frame", dat_samp_en, 1);
    #2 RST = 1'b0;
    #1;
    check("t6_rst_edge", edge_cnt, 0);
    check("t6_rst_samp_en", dat_samp_en, 0);
    check("t6_rst_pdata", P_DATA, 8'h00);
    check("t6_rst_pulses", {data_valid, par_err, stp_err}, 3'b000);
    RX_IN = 1'b1;
    tick(); tick();
    RST = 1'b1;
    repeat (3) tick();
    check("t6_no_pulse_after_rst", {data_valid, par_err, stp_err}, 3'b000);
    Prescale = 6'd4;
    send_frame(8'h3C, 0, 1'b0, 1'b1, 8);
    check("t6_dv", data_valid, 1);
    check("t6_pdata", P_DATA, 8'h3C);
    check("t6_serr", stp_err, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
